// File: rtl/cw_access_sequencer.sv
// Control-word decode and per-counter byte sequencing for a three-counter timer.
// Optional feature macro: READBACK_CMD_EN (SC=11 read-back command; otherwise ignored).
module cw_access_sequencer #(
  parameter logic [2:0] RST_MODE = 3'd0,
  parameter logic [1:0] RST_RW   = 2'b00
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic [1:0] Add_bus,
  input  logic       RW_bus,
  input  logic       acc_valid,
  input  logic [7:0] Data_in,
  output logic [8:0] mode,
  output logic [2:0] bcd,
  output logic [5:0] rw_mode,
  output logic [2:0] cw_load,
  output logic [2:0] wr_lsb,
  output logic [2:0] wr_msb,
  output logic [2:0] count_written,
  output logic [2:0] rd_msb,
  output logic [2:0] latch_cnt,
  output logic [2:0] latch_sts
);

  logic [8:0] mode_q, mode_d;
  logic [2:0] bcd_q, bcd_d;
  logic [5:0] rw_q, rw_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] rd_msb_q, rd_msb_d;
  logic [2:0] cw_load_q, cw_load_d;
  logic [2:0] wr_lsb_q, wr_lsb_d;
  logic [2:0] wr_msb_q, wr_msb_d;
  logic [2:0] cnt_wr_q, cnt_wr_d;
  logic [2:0] latch_cnt_q, latch_cnt_d;
`ifdef READBACK_CMD_EN
  logic [2:0] latch_sts_q, latch_sts_d;
`endif

  logic       is_wr;
  logic       is_rd;
  logic [1:0] sc;
  logic [1:0] rw_field;

  // Modes 6 and 7 are aliases of 2 and 3 on the 8253/8254
  function automatic logic [2:0] map_mode(input logic [2:0] m);
    return (m[2] & m[1]) ? {1'b0, m[1:0]} : m;
  endfunction

  // A Z/X RW_bus fails both equality tests, so the access falls through as a no-op
  assign is_wr    = acc_valid && (RW_bus == 1'b0);
  assign is_rd    = acc_valid && (RW_bus == 1'b1);
  assign sc       = Data_in[7:6];
  assign rw_field = Data_in[5:4];

  always_comb begin
    mode_d      = mode_q;
    bcd_d       = bcd_q;
    rw_d        = rw_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_msb_d    = rd_msb_q;
    cw_load_d   = 3'b000;
    wr_lsb_d    = 3'b000;
    wr_msb_d    = 3'b000;
    cnt_wr_d    = 3'b000;
    latch_cnt_d = 3'b000;
`ifdef READBACK_CMD_EN
    latch_sts_d = 3'b000;
`endif

    if (Add_bus == 2'b11) begin
      if (is_wr) begin
        for (int i = 0; i < 3; i++) begin
          if (sc == i[1:0]) begin
            if (rw_field == 2'b00) begin
              latch_cnt_d[i] = 1'b1;
            end else begin
              rw_d[2*i +: 2]   = rw_field;
              mode_d[3*i +: 3] = map_mode(Data_in[3:1]);
              bcd_d[i]         = Data_in[0];
              wr_ptr_d[i]      = 1'b0;
              rd_ptr_d[i]      = 1'b0;
              rd_msb_d[i]      = 1'b0;
              cw_load_d[i]     = 1'b1;
            end
          end
        end
`ifdef READBACK_CMD_EN
        // Read-back: Data_in[5]/[4] are active-low count/status selects
        if (sc == 2'b11) begin
          for (int i = 0; i < 3; i++) begin
            if (Data_in[i+1]) begin
              if (!Data_in[5]) begin
                latch_cnt_d[i] = 1'b1;
                rd_ptr_d[i]    = 1'b0;
              end
              if (!Data_in[4]) latch_sts_d[i] = 1'b1;
            end
          end
        end
`endif
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (Add_bus == i[1:0]) begin
          if (is_wr) begin
            case (rw_q[2*i +: 2])
              2'b01: begin
                wr_lsb_d[i] = 1'b1;
                cnt_wr_d[i] = 1'b1;
              end
              2'b10: begin
                wr_msb_d[i] = 1'b1;
                cnt_wr_d[i] = 1'b1;
              end
              2'b11: begin
                if (!wr_ptr_q[i]) begin
                  wr_lsb_d[i] = 1'b1;
                  wr_ptr_d[i] = 1'b1;
                end else begin
                  wr_msb_d[i] = 1'b1;
                  cnt_wr_d[i] = 1'b1;
                  wr_ptr_d[i] = 1'b0;
                end
              end
              default: ;
            endcase
          end else if (is_rd) begin
            case (rw_q[2*i +: 2])
              2'b01: rd_msb_d[i] = 1'b0;
              2'b10: rd_msb_d[i] = 1'b1;
              2'b11: begin
                rd_msb_d[i] = rd_ptr_q[i];
                rd_ptr_d[i] = ~rd_ptr_q[i];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      mode_q      <= {3{RST_MODE}};
      bcd_q       <= 3'b000;
      rw_q        <= {3{RST_RW}};
      wr_ptr_q    <= 3'b000;
      rd_ptr_q    <= 3'b000;
      rd_msb_q    <= 3'b000;
      cw_load_q   <= 3'b000;
      wr_lsb_q    <= 3'b000;
      wr_msb_q    <= 3'b000;
      cnt_wr_q    <= 3'b000;
      latch_cnt_q <= 3'b000;
    end else begin
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      rw_q        <= rw_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_msb_q    <= rd_msb_d;
      cw_load_q   <= cw_load_d;
      wr_lsb_q    <= wr_lsb_d;
      wr_msb_q    <= wr_msb_d;
      cnt_wr_q    <= cnt_wr_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

`ifdef READBACK_CMD_EN
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) latch_sts_q <= 3'b000;
    else       latch_sts_q <= latch_sts_d;
  end
  assign latch_sts = latch_sts_q;
`else
  assign latch_sts = 3'b000;
`endif

  assign mode          = mode_q;
  assign bcd           = bcd_q;
  assign rw_mode       = rw_q;
  assign cw_load       = cw_load_q;
  assign wr_lsb        = wr_lsb_q;
  assign wr_msb        = wr_msb_q;
  assign count_written = cnt_wr_q;
  assign rd_msb        = rd_msb_q;
  assign latch_cnt     = latch_cnt_q;

endmodule

// File: tb/tb_cw_access_sequencer.sv
// Directed self-checking bench for cw_access_sequencer (honours READBACK_CMD_EN).
module tb_cw_access_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] add_bus;
  logic       rw_bus;
  logic       acc_valid;
  logic [7:0] data_in;
  logic [8:0] mode;
  logic [2:0] bcd;
  logic [5:0] rw_mode;
  logic [2:0] cw_load;
  logic [2:0] wr_lsb;
  logic [2:0] wr_msb;
  logic [2:0] count_written;
  logic [2:0] rd_msb;
  logic [2:0] latch_cnt;
  logic [2:0] latch_sts;

  int n_compared;
  int n_mismatched;

  cw_access_sequencer dut (
    .CLK          (clk),
    ._RST         (rst_n),
    .Add_bus      (add_bus),
    .RW_bus       (rw_bus),
    .acc_valid    (acc_valid),
    .Data_in      (data_in),
    .mode         (mode),
    .bcd          (bcd),
    .rw_mode      (rw_mode),
    .cw_load      (cw_load),
    .wr_lsb       (wr_lsb),
    .wr_msb       (wr_msb),
    .count_written(count_written),
    .rd_msb       (rd_msb),
    .latch_cnt    (latch_cnt),
    .latch_sts    (latch_sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access for one cycle; returns on the following negedge, where its result is visible
  task automatic do_access(input logic [1:0] addr, input logic rw, input logic [7:0] data);
    add_bus   = addr;
    rw_bus    = rw;
    data_in   = data;
    acc_valid = 1'b1;
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_valid = 1'b0; add_bus = 2'b00; rw_bus = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    n_compared++; if (mode !== 9'd0) begin n_mismatched++; $display("[TB] FAIL reset_mode got %h expected %h", mode, 9'd0); end
    n_compared++; if (rw_mode !== 6'd0) begin n_mismatched++; $display("[TB] FAIL reset_rw_mode got %h expected %h", rw_mode, 6'd0); end
    n_compared++; if ({bcd, rd_msb, cw_load, wr_lsb, wr_msb, count_written, latch_cnt, latch_sts} !== 24'd0) begin
      n_mismatched++; $display("[TB] FAIL reset_flags got %h expected 0", {bcd, rd_msb, cw_load, wr_lsb, wr_msb, count_written, latch_cnt, latch_sts}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unprogrammed();
    do_access(2'b00, 1'b0, 8'h55);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== 9'd0) begin n_mismatched++; $display("[TB] FAIL unprog_pulses got %h expected 0", {wr_lsb, wr_msb, count_written}); end
    n_compared++; if (rw_mode !== 6'd0) begin n_mismatched++; $display("[TB] FAIL unprog_rw_mode got %h expected 0", rw_mode); end
    n_compared++; if (mode !== 9'd0) begin n_mismatched++; $display("[TB] FAIL unprog_mode got %h expected 0", mode); end
  endtask

  task automatic test_lsb_msb();
    do_access(2'b11, 1'b0, 8'h34);
    n_compared++; if (cw_load !== 3'b001) begin n_mismatched++; $display("[TB] FAIL cw34_load got %b expected 001", cw_load); end
    n_compared++; if (rw_mode !== 6'b000011) begin n_mismatched++; $display("[TB] FAIL cw34_rw_mode got %b expected 000011", rw_mode); end
    n_compared++; if (mode !== 9'b000_000_010) begin n_mismatched++; $display("[TB] FAIL cw34_mode got %b expected 000000010", mode); end
    @(negedge clk);
    n_compared++; if (cw_load !== 3'b000) begin n_mismatched++; $display("[TB] FAIL cw_load_width got %b expected 000", cw_load); end
    do_access(2'b00, 1'b0, 8'hE8);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b001, 3'b000, 3'b000}) begin
      n_mismatched++; $display("[TB] FAIL c0_lsb got %b expected 001000000", {wr_lsb, wr_msb, count_written}); end
    do_access(2'b00, 1'b0, 8'h03);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b000, 3'b001, 3'b001}) begin
      n_mismatched++; $display("[TB] FAIL c0_msb got %b expected 000001001", {wr_lsb, wr_msb, count_written}); end
  endtask

  task automatic test_cw_mid_sequence();
    do_access(2'b11, 1'b0, 8'h7D);
    n_compared++; if (cw_load !== 3'b010) begin n_mismatched++; $display("[TB] FAIL cw7d_load got %b expected 010", cw_load); end
    n_compared++; if (bcd !== 3'b010) begin n_mismatched++; $display("[TB] FAIL cw7d_bcd got %b expected 010", bcd); end
    n_compared++; if (mode[5:3] !== 3'd2) begin n_mismatched++; $display("[TB] FAIL cw7d_mode_map got %0d expected 2", mode[5:3]); end
    do_access(2'b01, 1'b0, 8'h12);
    n_compared++; if (wr_lsb !== 3'b010) begin n_mismatched++; $display("[TB] FAIL c1_first_lsb got %b expected 010", wr_lsb); end
    do_access(2'b11, 1'b0, 8'h7D);
    do_access(2'b01, 1'b0, 8'h34);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b010, 3'b000, 3'b000}) begin
      n_mismatched++; $display("[TB] FAIL c1_ptr_reset got %b expected 010000000", {wr_lsb, wr_msb, count_written}); end
  endtask

  task automatic test_read_msb_only();
    do_access(2'b11, 1'b0, 8'hA6);
    n_compared++; if (rw_mode[5:4] !== 2'b10) begin n_mismatched++; $display("[TB] FAIL cwa6_rw got %b expected 10", rw_mode[5:4]); end
    n_compared++; if (mode[8:6] !== 3'd3) begin n_mismatched++; $display("[TB] FAIL cwa6_mode got %0d expected 3", mode[8:6]); end
    for (int k = 0; k < 2; k++) begin
      do_access(2'b10, 1'b1, 8'h00);
      n_compared++; if (rd_msb[2] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL c2_read%0d_msb got %b expected 1", k, rd_msb[2]); end
    end
    do_access(2'b10, 1'b0, 8'h44);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b000, 3'b100, 3'b100}) begin
      n_mismatched++; $display("[TB] FAIL c2_msb_write got %b expected 000100100", {wr_lsb, wr_msb, count_written}); end
    do_access(2'b11, 1'b0, 8'h80);
    n_compared++; if (latch_cnt !== 3'b100) begin n_mismatched++; $display("[TB] FAIL c2_latch got %b expected 100", latch_cnt); end
    n_compared++; if ({mode[8:6], cw_load} !== {3'd3, 3'b000}) begin n_mismatched++; $display("[TB] FAIL c2_latch_keeps_mode got %b expected 011000", {mode[8:6], cw_load}); end
  endtask

  task automatic test_rw11_read();
    logic [2:0] exp_seq;
    exp_seq = 3'b010;
    for (int k = 0; k < 3; k++) begin
      do_access(2'b00, 1'b1, 8'h00);
      n_compared++; if (rd_msb[0] !== exp_seq[k]) begin n_mismatched++; $display("[TB] FAIL c0_read%0d_msb got %b expected %b", k, rd_msb[0], exp_seq[k]); end
    end
    n_compared++; if (rd_msb[2] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL c2_rd_undisturbed got %b expected 1", rd_msb[2]); end
  endtask

  task automatic test_rw01();
    do_access(2'b11, 1'b0, 8'h50);
    n_compared++; if ({rw_mode[3:2], mode[5:3], bcd[1]} !== {2'b01, 3'd0, 1'b0}) begin
      n_mismatched++; $display("[TB] FAIL cw50_fields got %b expected 010000", {rw_mode[3:2], mode[5:3], bcd[1]}); end
    do_access(2'b01, 1'b0, 8'h99);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b010, 3'b000, 3'b010}) begin
      n_mismatched++; $display("[TB] FAIL c1_lsb_only got %b expected 010000010", {wr_lsb, wr_msb, count_written}); end
    do_access(2'b01, 1'b1, 8'h00);
    n_compared++; if (rd_msb[1] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL c1_read_lsb got %b expected 0", rd_msb[1]); end
  endtask

  task automatic test_cwr_read();
    do_access(2'b11, 1'b1, 8'h34);
    n_compared++; if ({cw_load, latch_cnt, latch_sts, rw_mode} !== {9'd0, 6'b100111}) begin
      n_mismatched++; $display("[TB] FAIL cwr_read_noop got %b expected 000000000100111", {cw_load, latch_cnt, latch_sts, rw_mode}); end
  endtask

  task automatic test_readback();
    logic [2:0] exp_lc, exp_ls;
`ifdef READBACK_CMD_EN
    exp_lc = 3'b101; exp_ls = 3'b101;
`else
    exp_lc = 3'b000; exp_ls = 3'b000;
`endif
    do_access(2'b11, 1'b0, 8'hCA);
    n_compared++; if (latch_cnt !== exp_lc) begin n_mismatched++; $display("[TB] FAIL readback_cnt got %b expected %b", latch_cnt, exp_lc); end
    n_compared++; if (latch_sts !== exp_ls) begin n_mismatched++; $display("[TB] FAIL readback_sts got %b expected %b", latch_sts, exp_ls); end
    n_compared++; if ({mode, rw_mode, cw_load} !== {9'b011_000_010, 6'b100111, 3'b000}) begin
      n_mismatched++; $display("[TB] FAIL readback_keeps_cfg got %b expected 011000010100111000", {mode, rw_mode, cw_load}); end
  endtask

  task automatic test_back_to_back();
    do_access(2'b00, 1'b0, 8'hAA);
    n_compared++; if (wr_lsb !== 3'b001) begin n_mismatched++; $display("[TB] FAIL b2b_first got %b expected 001", wr_lsb); end
    do_access(2'b00, 1'b0, 8'hBB);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== {3'b000, 3'b001, 3'b001}) begin
      n_mismatched++; $display("[TB] FAIL b2b_second got %b expected 000001001", {wr_lsb, wr_msb, count_written}); end
  endtask

  task automatic test_reset_mid();
    do_access(2'b00, 1'b0, 8'h11);
    n_compared++; if (wr_lsb !== 3'b001) begin n_mismatched++; $display("[TB] FAIL mid_lsb got %b expected 001", wr_lsb); end
    rst_n = 1'b0;
    #1;
    n_compared++; if (wr_lsb !== 3'b000) begin n_mismatched++; $display("[TB] FAIL async_pulse_clear got %b expected 000", wr_lsb); end
    n_compared++; if ({mode, rw_mode, bcd, rd_msb} !== 21'd0) begin
      n_mismatched++; $display("[TB] FAIL async_state_clear got %h expected 0", {mode, rw_mode, bcd, rd_msb}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(2'b00, 1'b0, 8'h22);
    n_compared++; if ({wr_lsb, wr_msb, count_written} !== 9'd0) begin
      n_mismatched++; $display("[TB] FAIL post_reset_ignored got %b expected 0", {wr_lsb, wr_msb, count_written}); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_unprogrammed();
    test_lsb_msb();
    test_cw_mid_sequence();
    test_read_msb_only();
    test_rw11_read();
    test_rw01();
    test_cwr_read();
    test_readback();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
